// File: rtl/mem_pkg.sv
// Shared types and default geometry for the system memory subsystem.
package mem_pkg;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 16;
    localparam int LATENCY = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_ILL = 2'd2
    } mem_op_t;

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with one 16-bit little-endian port; the second byte wraps
// at the top of the address space.
module mem_byte_array #(
    parameter int ADDR_W = mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    localparam int BANK_W = ADDR_W - 1;

    // Bytes a and a+1 always live in different banks (even/odd), so each bank
    // needs only one write port. An odd address pushes the even bank to the next
    // row, which wraps to row 0 at the top of memory.
    logic [BANK_W-1:0] row_lo;
    logic [BANK_W-1:0] row_hi;
    logic              odd;
    logic [BANK_W-1:0] bank_row   [2];
    logic [7:0]        bank_wdata [2];
    logic [7:0]        bank_rdata [2];

    always_comb begin
        row_lo        = addr[ADDR_W-1:1];
        row_hi        = row_lo + BANK_W'(1);
        odd           = addr[0];
        bank_row[0]   = odd ? row_hi : row_lo;
        bank_row[1]   = row_lo;
        bank_wdata[0] = odd ? wdata[15:8] : wdata[7:0];
        bank_wdata[1] = odd ? wdata[7:0]  : wdata[15:8];
        rdata         = odd ? {bank_rdata[0], bank_rdata[1]}
                            : {bank_rdata[1], bank_rdata[0]};
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] bank [2**BANK_W];

            always_ff @(posedge clk) begin
                if (we) begin
                    bank[bank_row[gi]] <= bank_wdata[gi];
                end
            end

            assign bank_rdata[gi] = bank[bank_row[gi]];
        end
    endgenerate

endmodule

// File: rtl/sys_mem_ctrl.sv
// System memory controller: four-phase req/resp handshake, fixed access latency,
// 16-bit little-endian accesses into a byte-addressed store.
module sys_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int LATENCY = mem_pkg::LATENCY
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_resp,
    output logic              mem_err,
    output logic              busy
);

    mem_state_t        state_reg, state_next;
    mem_op_t           op_reg, op_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              resp_reg, resp_next;
    logic              err_reg, err_next;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            op_reg    <= OP_RD;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            resp_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            resp_reg  <= resp_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        resp_next  = resp_reg;
        err_next   = err_reg;
        mem_we     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cs && (read_req || write_req)) begin
                    if (read_req && write_req) begin
                        op_next = OP_ILL;
                    end else if (read_req) begin
                        op_next = OP_RD;
                    end else begin
                        op_next = OP_WR;
                    end
                    addr_next  = addr;
                    wdata_next = wdata;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    // Commit happens on the same edge that raises mem_resp; a reset on
                    // that edge must suppress it, so the enable is qualified by reset_n.
                    mem_we     = (op_reg == OP_WR) && reset_n;
                    resp_next  = 1'b1;
                    err_next   = (op_reg == OP_ILL);
                    state_next = RESP;
                    if (op_reg == OP_RD) begin
                        rdata_next = mem_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                if (!read_req && !write_req) begin
                    resp_next  = 1'b0;
                    err_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rdata    = rdata_reg;
    assign mem_resp = resp_reg;
    assign mem_err  = err_reg;
    assign busy     = (state_reg != IDLE);

endmodule
